// File: rtl/bpm_ctrl_pkg.sv
// Shared types and helpers for the BPM ramp controller: FSM state encoding,
// a bounded-step approach function and a sample clamp.
package bpm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        LOCK  = 2'd2,
        DECAY = 2'd3
    } ctrl_state_t;

    // Callers zero-extend their BPM values to 16 bits, which keeps the
    // helpers independent of the module parameters.
    function automatic logic [15:0] step_toward(input logic [15:0] est,
                                                input logic [15:0] goal,
                                                input logic [15:0] step);
        logic [15:0] diff;
        if (est >= goal) begin
            diff = est - goal;
            step_toward = (diff <= step) ? goal : est - step;
        end else begin
            diff = goal - est;
            step_toward = (diff <= step) ? goal : est + step;
        end
    endfunction

    function automatic logic [15:0] clamp_bpm(input logic [15:0] sample,
                                              input logic [15:0] max_bpm);
        clamp_bpm = (sample > max_bpm) ? max_bpm : sample;
    endfunction

endpackage

// File: rtl/bpm_block_averager.sv
// Accepts raw BPM samples, clamps them and averages fixed blocks of
// 2^AVG_LOG2 samples into a registered target with a same-cycle update strobe.
module bpm_block_averager
    import bpm_ctrl_pkg::*;
#(
    parameter int MAX_BPM  = 200,
    parameter int BPM_W    = $clog2(MAX_BPM + 1),
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BPM_W-1:0] bpm_in,
    input  logic             bpm_valid,
    output logic             bpm_ready,
    output logic [BPM_W-1:0] target_bpm,
    output logic             tgt_upd,
    output logic [BPM_W-1:0] new_target
);

    localparam int ACC_W = BPM_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [AVG_LOG2-1:0] cnt;
    logic [BPM_W-1:0]    sample;
    logic [ACC_W-1:0]    sum;
    logic                accept;

    assign accept = bpm_valid && bpm_ready;
    assign sample = BPM_W'(clamp_bpm(16'(bpm_in), 16'(MAX_BPM)));
    assign sum    = acc + ACC_W'(sample);

    // The completing sample is folded into the average; the strobe fires in
    // the accepting cycle so the controller can act on it at the same edge
    // that loads target_bpm.
    assign new_target = BPM_W'(sum >> AVG_LOG2);
    assign tgt_upd    = accept && (cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bpm_ready  <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            target_bpm <= '0;
        end else begin
            bpm_ready <= 1'b1;
            if (accept) begin
                if (tgt_upd) begin
                    target_bpm <= new_target;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bpm_ramp_controller.sv
// Drives the brightness filter's BPM estimate and enable: ramps toward the
// averaged target only at frame boundaries and decays to zero on silence.
module bpm_ramp_controller
    import bpm_ctrl_pkg::*;
#(
    parameter int MAX_BPM        = 200,
    parameter int BPM_W          = $clog2(MAX_BPM + 1),
    parameter int AVG_LOG2       = 2,
    parameter int RAMP_STEP      = 2,
    parameter int TIMEOUT_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BPM_W-1:0] bpm_in,
    input  logic             bpm_valid,
    output logic             bpm_ready,
    input  logic             frame_start,
    input  logic             enable_req,
    output logic [BPM_W-1:0] bpm_estimate,
    output logic             filter_enable,
    output logic [BPM_W-1:0] target_bpm,
    output logic [1:0]       state
);

    localparam int FCNT_W = $clog2(TIMEOUT_FRAMES + 1);

    ctrl_state_t       state_q, state_n;
    logic [BPM_W-1:0]  est_n, goal, step_est, new_target;
    logic [FCNT_W-1:0] fcnt, fcnt_n;
    logic              en_n, tgt_upd, run, timeout;

    bpm_block_averager #(
        .MAX_BPM  (MAX_BPM),
        .BPM_W    (BPM_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk        (clk),
        .reset      (reset),
        .bpm_in     (bpm_in),
        .bpm_valid  (bpm_valid),
        .bpm_ready  (bpm_ready),
        .target_bpm (target_bpm),
        .tgt_upd    (tgt_upd),
        .new_target (new_target)
    );

    assign state = state_q;

    always_comb begin
        state_n  = state_q;
        est_n    = bpm_estimate;
        fcnt_n   = fcnt;
        en_n     = filter_enable;
        goal     = (state_q == DECAY) ? '0 : target_bpm;
        step_est = BPM_W'(step_toward(16'(bpm_estimate), 16'(goal), 16'(RAMP_STEP)));
        run      = (state_q == RAMP) || (state_q == LOCK);
        timeout  = frame_start && run && !tgt_upd &&
                   (fcnt >= FCNT_W'(TIMEOUT_FRAMES - 1));

        // The step always uses the registered target; a coincident update
        // only becomes the goal from the following frame.
        if (frame_start && state_q != IDLE)
            est_n = step_est;

        if (tgt_upd)
            fcnt_n = '0;
        else if (frame_start && run && fcnt < FCNT_W'(TIMEOUT_FRAMES))
            fcnt_n = fcnt + 1'b1;

        case (state_q)
            IDLE: begin
                if (tgt_upd)
                    state_n = RAMP;
            end
            RAMP: begin
                if (timeout)
                    state_n = DECAY;
                else if (!tgt_upd && frame_start && step_est == target_bpm)
                    state_n = LOCK;
            end
            LOCK: begin
                if (tgt_upd) begin
                    if (new_target != est_n)
                        state_n = RAMP;
                end else if (timeout) begin
                    state_n = DECAY;
                end
            end
            DECAY: begin
                if (tgt_upd)
                    state_n = RAMP;
                else if (frame_start && step_est == '0)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (frame_start)
            en_n = enable_req && (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bpm_estimate  <= '0;
            filter_enable <= 1'b0;
            fcnt          <= '0;
        end else begin
            state_q       <= state_n;
            bpm_estimate  <= est_n;
            filter_enable <= en_n;
            fcnt          <= fcnt_n;
        end
    end

endmodule

// File: tb/tb_bpm_ramp_controller.sv
// Scoreboard bench for bpm_ramp_controller: directed stimulus queues expected
// output snapshots, a negedge monitor pops and compares them.
module tb_bpm_ramp_controller;

    localparam int S_IDLE  = 0;
    localparam int S_RAMP  = 1;
    localparam int S_LOCK  = 2;
    localparam int S_DECAY = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bpm_in;
    logic       bpm_valid;
    logic       bpm_ready;
    logic       frame_start;
    logic       enable_req;
    logic [7:0] bpm_estimate;
    logic       filter_enable;
    logic [7:0] target_bpm;
    logic [1:0] state;

    typedef struct {
        string name;
        int    est;
        int    en;
        int    tgt;
        int    st;
        int    rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bpm_ramp_controller dut (
        .clk           (clk),
        .reset         (reset),
        .bpm_in        (bpm_in),
        .bpm_valid     (bpm_valid),
        .bpm_ready     (bpm_ready),
        .frame_start   (frame_start),
        .enable_req    (enable_req),
        .bpm_estimate  (bpm_estimate),
        .filter_enable (filter_enable),
        .target_bpm    (target_bpm),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d", n, f, act, exp);
        end
    endtask

    // Monitor: compares every pending snapshot at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "est", int'(bpm_estimate), e.est);
            chk(e.name, "en", int'(filter_enable), e.en);
            chk(e.name, "tgt", int'(target_bpm), e.tgt);
            chk(e.name, "state", int'(state), e.st);
            chk(e.name, "ready", int'(bpm_ready), e.rdy);
        end
    end

    task automatic expect_out(input string n, input int est, input int en,
                              input int tgt, input int st, input int rdy = 1);
        exp_t e;
        e.name = n; e.est = est; e.en = en; e.tgt = tgt; e.st = st; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit with_frame = 1'b0);
        bpm_in      = 8'(v);
        bpm_valid   = 1'b1;
        frame_start = with_frame;
        cyc();
        bpm_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bpm_in = '0; bpm_valid = 1'b0;
        frame_start = 1'b0; enable_req = 1'b0;
        repeat (2) cyc();
        expect_out("reset", 0, 0, 0, S_IDLE, 0);
        reset = 1'b0;
        cyc();
        expect_out("release", 0, 0, 0, S_IDLE, 1);

        // Ramp to lock: 404/4 = 101, +2 per frame, lock on frame 51.
        enable_req = 1'b1;
        send(100); send(100); send(100);
        expect_out("avg_partial", 0, 0, 0, S_IDLE);
        send(104);
        expect_out("avg_done", 0, 0, 101, S_RAMP);
        cyc();
        expect_out("no_frame_hold", 0, 0, 101, S_RAMP);
        for (int i = 1; i <= 51; i++) begin
            frame();
            if (i == 1)  expect_out("ramp_f1", 2, 1, 101, S_RAMP);
            if (i == 50) expect_out("ramp_f50", 100, 1, 101, S_RAMP);
            if (i == 51) expect_out("ramp_f51", 101, 1, 101, S_LOCK);
        end

        // Enable gating: mid-frame change waits for the next frame_start.
        enable_req = 1'b0;
        cyc(); expect_out("en_hold1", 101, 1, 101, S_LOCK);
        cyc(); expect_out("en_hold2", 101, 1, 101, S_LOCK);
        frame(); expect_out("en_off", 101, 0, 101, S_LOCK);
        enable_req = 1'b1;
        cyc(); expect_out("en_hold3", 101, 0, 101, S_LOCK);
        frame(); expect_out("en_on", 101, 1, 101, S_LOCK);

        // Down to 50: 101 -> 51 in 25 frames, 50 on frame 26.
        repeat (4) send(50);
        expect_out("tgt50", 101, 1, 50, S_RAMP);
        for (int i = 1; i <= 26; i++) begin
            frame();
            if (i == 25) expect_out("down_f25", 51, 1, 50, S_RAMP);
            if (i == 26) expect_out("down_f26", 50, 1, 50, S_LOCK);
        end

        // Completing sample coincides with frame_start.
        repeat (3) send(60);
        send(60, 1'b1);
        expect_out("simul", 50, 1, 60, S_RAMP);
        frame();
        expect_out("simul_next", 52, 1, 60, S_RAMP);

        // Reset mid-ramp with a partial block pending.
        send(30);
        #1 reset = 1'b1;
        expect_out("mid_reset", 0, 0, 0, S_IDLE, 0);
        cyc();
        reset = 1'b0;
        cyc();
        expect_out("mid_release", 0, 0, 0, S_IDLE, 1);
        repeat (3) send(40);
        expect_out("no_residue", 0, 0, 0, S_IDLE);
        send(40);
        expect_out("tgt40", 0, 0, 40, S_RAMP);

        // Clamp: 250 -> 200, reached after 100 frames.
        repeat (4) send(250);
        expect_out("clamp_tgt", 0, 0, 200, S_RAMP);
        for (int i = 1; i <= 100; i++) begin
            frame();
            if (i == 1)   expect_out("clamp_f1", 2, 1, 200, S_RAMP);
            if (i == 99)  expect_out("clamp_f99", 198, 1, 200, S_RAMP);
            if (i == 100) expect_out("clamp_f100", 200, 1, 200, S_LOCK);
        end

        // Timeout: lock at 10 then silence until frame 120 after the update.
        repeat (4) send(10);
        expect_out("tgt10", 200, 1, 10, S_RAMP);
        for (int i = 1; i <= 126; i++) begin
            frame();
            if (i == 94)  expect_out("to_f94", 12, 1, 10, S_RAMP);
            if (i == 95)  expect_out("to_f95", 10, 1, 10, S_LOCK);
            if (i == 119) expect_out("to_f119", 10, 1, 10, S_LOCK);
            if (i == 120) expect_out("to_f120", 10, 1, 10, S_DECAY);
            if (i == 121) expect_out("decay8", 8, 1, 10, S_DECAY);
            if (i == 124) expect_out("decay2", 2, 1, 10, S_DECAY);
            if (i == 125) expect_out("decay0", 0, 0, 10, S_IDLE);
            if (i == 126) expect_out("idle_stay", 0, 0, 10, S_IDLE);
        end

        // Zero target from IDLE: RAMP, then LOCK at the next frame.
        repeat (4) send(0);
        expect_out("tgt0", 0, 0, 0, S_RAMP);
        frame();
        expect_out("tgt0_lock", 0, 1, 0, S_LOCK);

        cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpm_ramp_controller.md
Name: bpm_ramp_controller

Overview:
- Drives the BPM_estimate and filter_enable inputs of the brightness filter.
- Accepts raw BPM samples over a valid/ready handshake and averages them in fixed blocks to form a target.
- Ramps the applied BPM toward the target by a bounded step, only at frame boundaries, so brightness never changes mid-frame and never jumps.
- Decays brightness to zero when the BPM source goes silent.

Parameters:
- MAX_BPM, 200, upper clamp for samples and outputs.
- BPM_W, $clog2(MAX_BPM+1) (=8), width of all BPM values.
- AVG_LOG2, 2, averaging block is 2^AVG_LOG2 samples.
- RAMP_STEP, 2, maximum change of bpm_estimate per frame.
- TIMEOUT_FRAMES, 120, frames without a new target before decay.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- bpm_in, input, BPM_W, raw BPM sample.
- bpm_valid, input, 1, bpm_in valid.
- bpm_ready, output, 1, sample accepted when bpm_valid && bpm_ready.
- frame_start, input, 1, single-cycle pulse at the start of each video frame.
- enable_req, input, 1, user filter enable (switch level).
- bpm_estimate, output, BPM_W, registered applied BPM, to the filter.
- filter_enable, output, 1, registered enable, to the filter.
- target_bpm, output, BPM_W, current averaged target.
- state, output, 2, current FSM state (debug).

Behaviour:
- Reset (async, active-high) clears everything: bpm_estimate=0, filter_enable=0, target_bpm=0, state=IDLE, bpm_ready=0 while reset is asserted, accumulator, sample count and frame counter cleared.
- bpm_ready=1 in every state once out of reset.
- Each accepted sample is clamped to MAX_BPM, then added to an accumulator of width BPM_W+AVG_LOG2.
- On the 2^AVG_LOG2-th accepted sample:
  - target_bpm <= (acc + sample) >> AVG_LOG2, truncating; the completing sample is included.
  - Accumulator and count clear.
  - A one-cycle internal tgt_upd pulse is raised; target_bpm is visible the next cycle.
- Ramp step, evaluated only on frame_start:
  - If |goal - est| <= RAMP_STEP then est <= goal, else est <= est ± RAMP_STEP.
  - goal is target_bpm, or 0 in DECAY.
  - No overflow or underflow is possible.
- bpm_estimate and filter_enable change only in the cycle after a frame_start.
- filter_enable <= enable_req && (next state != IDLE); updated on frame_start only. An enable_req change mid-frame takes effect at the next frame.
- Frame counter:
  - Increments on frame_start in RAMP and LOCK; saturates at TIMEOUT_FRAMES.
  - Cleared on tgt_upd.
- FSM states (2-bit):
  - IDLE: est=0. On tgt_upd -> RAMP.
  - RAMP: on frame_start apply the step; if the new est equals target -> LOCK.
  - LOCK: on a tgt_upd with a new target != est -> RAMP.
  - RAMP/LOCK timeout: frame counter reaching TIMEOUT_FRAMES (on a frame_start) -> DECAY.
  - DECAY: on frame_start step toward 0; when est reaches 0 -> IDLE and filter_enable clears on that same update. On tgt_upd -> RAMP.
- tgt_upd and frame_start in the same cycle:
  - The step uses the old target_bpm.
  - The frame counter clears (update wins over increment).
  - The state transition from tgt_upd is taken.
  - The new target takes effect at the next frame_start.
- A target of 0 from IDLE: go to RAMP, which moves to LOCK at the next frame_start with est=0.
- Reset mid-ramp: immediate return to the reset values, no residual accumulator contents.

Decomposition:
- Package bpm_ctrl_pkg holds:
  - the state enum (IDLE=0, RAMP=1, LOCK=2, DECAY=3);
  - a function step_toward(est, goal, step);
  - a function clamp_bpm.
- Sub-module bpm_block_averager: handshake, clamp, accumulate, target_bpm and tgt_upd generation.
- The top level holds the FSM, frame counter and output registers.

Test Plan:
- Reset check: assert reset mid-operation -> bpm_estimate=0, filter_enable=0, target_bpm=0, state=IDLE asynchronously; bpm_ready=1 after release.
- Ramp to lock: samples 100,100,100,104, enable_req=1, then frame_start pulses -> target_bpm=101; est=2 after frame 1; est=100 after frame 50; est=101 and LOCK after frame 51; filter_enable=1 from frame 1.
- Clamp: four samples of 250 -> target_bpm=200; after 100 frames est=200, state=LOCK.
- Enable gating: toggle enable_req mid-frame -> filter_enable unchanged until the cycle after the next frame_start.
- Timeout decay: LOCK at est=10, then no samples for 120 frames -> DECAY; est=8,6,4,2,0 over the next 5 frames; IDLE and filter_enable=0 at est=0.
- Simultaneous events:
  - Setup: LOCK at 50, with a 4th sample completing target 60 in the same cycle as frame_start.
  - That frame: est stays 50, state -> RAMP, frame counter=0.
  - Next frame: est=52.
